regfile_wr_arbiter: RTL and testbench

//  Owns the single write port of the 4x32 register file. After reset it runs an init sequence

---
 rtl/regfile_wr_if.sv | 37 +++
 rtl/regfile_wr_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_if.sv
// Write-side bundle of the 4x32 register file: two valid/ready write
// requesters plus the single register-file write port and the init flag.
// master: requester/register-file side.  slave: the write arbiter.
interface regfile_wr_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
);
  // Requester 0
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_reg_no;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  // Requester 1
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_reg_no;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  // Register-file write port
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg_no;
  logic [DATA_W-1:0] write_data;
  logic              init_busy;

  modport master (
    output req0_valid, req0_reg_no, req0_data,
    output req1_valid, req1_reg_no, req1_data,
    input  req0_ready, req1_ready,
    input  reg_write, write_reg_no, write_data, init_busy
  );

  modport slave (
    input  req0_valid, req0_reg_no, req0_data,
    input  req1_valid, req1_reg_no, req1_data,
    output req0_ready, req1_ready,
    output reg_write, write_reg_no, write_data, init_busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Owner of the register-file write port. After reset it writes INIT_VALUE to
// registers 0..REG_N-1 on consecutive cycles, then arbitrates two valid/ready
// requesters onto the write port with one cycle of latency.
// Optional feature macro: RFARB_RR_EN
//   defined   -> round-robin when both requesters are valid
//   undefined -> fixed priority, requester 0 always wins
module regfile_wr_arbiter #(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 2,
  parameter int                 REG_N      = 4,
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_wr_if.slave  bus
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  // Counter must also hold REG_N, which marks "all init writes issued".
  localparam int CNT_W = $clog2(REG_N + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   init_cnt_q, init_cnt_d;
  logic               reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]  write_reg_no_q, write_reg_no_d;
  logic [DATA_W-1:0]  write_data_q, write_data_d;
  logic               prio0;
  logic               grant0, grant1;

`ifdef RFARB_RR_EN
  // 1 = requester 1 was granted last, so requester 0 wins the next tie.
  logic               last_grant_q, last_grant_d;
  assign prio0 = last_grant_q;
`else
  assign prio0 = 1'b1;
`endif

  // Combinational grant: only in S_RUN, a lone valid wins, ties go to prio0.
  always_comb begin
    grant0 = (state_q == S_RUN) && bus.req0_valid && (!bus.req1_valid || prio0);
    grant1 = (state_q == S_RUN) && bus.req1_valid && !(bus.req0_valid && prio0);
  end

  // Next-state logic for the init sequence and the registered write port.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    reg_write_d    = 1'b0;
    write_reg_no_d = write_reg_no_q;
    write_data_d   = write_data_q;
`ifdef RFARB_RR_EN
    last_grant_d   = last_grant_q;
`endif
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == CNT_W'(REG_N)) begin
          state_d = S_RUN;
        end else begin
          reg_write_d    = 1'b1;
          write_reg_no_d = ADDR_W'(init_cnt_q);
          write_data_d   = INIT_VALUE;
          init_cnt_d     = init_cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (grant0) begin
          reg_write_d    = 1'b1;
          write_reg_no_d = bus.req0_reg_no;
          write_data_d   = bus.req0_data;
`ifdef RFARB_RR_EN
          last_grant_d   = 1'b0;
`endif
        end else if (grant1) begin
          reg_write_d    = 1'b1;
          write_reg_no_d = bus.req1_reg_no;
          write_data_d   = bus.req1_data;
`ifdef RFARB_RR_EN
          last_grant_d   = 1'b1;
`endif
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and output registers; reset drops any in-flight write at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q        <= S_INIT;
      init_cnt_q     <= '0;
      reg_write_q    <= 1'b0;
      write_reg_no_q <= '0;
      write_data_q   <= '0;
`ifdef RFARB_RR_EN
      last_grant_q   <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      reg_write_q    <= reg_write_d;
      write_reg_no_q <= write_reg_no_d;
      write_data_q   <= write_data_d;
`ifdef RFARB_RR_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.reg_write    = reg_write_q;
  assign bus.write_reg_no = write_reg_no_q;
  assign bus.write_data   = write_data_q;
  assign bus.init_busy    = (state_q == S_INIT);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed init/arbitration/reset
// scenarios followed by randomized valid/ready traffic, all compared each
// cycle against a cycle-level model of the arbiter's rules.
module tb_regfile_wr_arbiter;
  localparam int          DATA_W     = 32;
  localparam int          ADDR_W     = 2;
  localparam int          REG_N      = 4;
  localparam logic [31:0] INIT_VALUE = 32'h0;
`ifdef RFARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  regfile_wr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc ();

  regfile_wr_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_N(REG_N), .INIT_VALUE(INIT_VALUE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file sitting behind the write port (storage only, no reset).
  logic [DATA_W-1:0] rf [REG_N];
  always @(posedge clk) begin
    if (ifc.reg_write) rf[ifc.write_reg_no] <= ifc.write_data;
  end

  // ---------------- behavioural model ----------------
  // m_edges counts rising edges since reset release, saturating once running:
  // edges 1..REG_N are the init writes, edge REG_N+1 enters run.
  int                m_edges;
  int                m_last;   // requester granted last (1 after reset)
  logic              m_we;
  logic [ADDR_W-1:0] m_no;
  logic [DATA_W-1:0] m_data;

  function automatic int winner(input logic v0, input logic v1);
    if (m_edges <= REG_N) return -1;
    if (v0 && v1)         return RR ? (m_last == 0 ? 1 : 0) : 0;
    if (v0)               return 0;
    if (v1)               return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_last  <= 1;
      m_we    <= 1'b0;
      m_no    <= '0;
      m_data  <= '0;
    end else begin
      if (m_edges < REG_N) begin
        m_we   <= 1'b1;
        m_no   <= ADDR_W'(m_edges);
        m_data <= INIT_VALUE;
      end else if (m_edges == REG_N) begin
        m_we <= 1'b0;
      end else begin
        case (winner(ifc.req0_valid, ifc.req1_valid))
          0: begin
            m_we <= 1'b1; m_no <= ifc.req0_reg_no; m_data <= ifc.req0_data; m_last <= 0;
          end
          1: begin
            m_we <= 1'b1; m_no <= ifc.req1_reg_no; m_data <= ifc.req1_data; m_last <= 1;
          end
          default: m_we <= 1'b0;
        endcase
      end
      if (m_edges <= REG_N) m_edges <= m_edges + 1;
    end
  end

  // Compare process: mid-cycle, whenever out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_reg_write",    ifc.reg_write,    m_we);
      check("m_write_reg_no", ifc.write_reg_no, m_no);
      check("m_write_data",   ifc.write_data,   m_data);
      check("m_init_busy",    ifc.init_busy,    m_edges <= REG_N);
      check("m_req0_ready",   ifc.req0_ready,   winner(ifc.req0_valid, ifc.req1_valid) == 0);
      check("m_req1_ready",   ifc.req1_ready,   winner(ifc.req0_valid, ifc.req1_valid) == 1);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic acc0, acc1;
  int   grants[$];

  // One clock: record handshakes mid-cycle, return just after the next rising edge.
  task automatic cycle(output logic a0, output logic a1);
    @(negedge clk);
    a0 = ifc.req0_valid & ifc.req0_ready;
    a1 = ifc.req1_valid & ifc.req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input int no, input logic [31:0] d);
    ifc.req0_valid = v; ifc.req0_reg_no = ADDR_W'(no); ifc.req0_data = d;
  endtask

  task automatic set_req1(input logic v, input int no, input logic [31:0] d);
    ifc.req1_valid = v; ifc.req1_reg_no = ADDR_W'(no); ifc.req1_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    set_req0(1'b0, 0, '0);
    set_req1(1'b0, 0, '0);

    // Reset values
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_reg_write",    ifc.reg_write,    1'b0);
    check("rst_write_reg_no", ifc.write_reg_no, 2'd0);
    check("rst_write_data",   ifc.write_data,   32'h0);
    check("rst_init_busy",    ifc.init_busy,    1'b1);
    check("rst_req0_ready",   ifc.req0_ready,   1'b0);
    check("rst_req1_ready",   ifc.req1_ready,   1'b0);
    #2 rst_n = 1'b1;

    // Init sequence; req0 raises valid in init cycle 2 and must be held off
    for (int k = 1; k <= REG_N + 1; k++) begin
      @(posedge clk); #1;
      if (k == 2) set_req0(1'b1, 1, 32'hF0F0F0F0);
      @(negedge clk);
      if (k <= REG_N) begin
        check("init_reg_write",    ifc.reg_write,    1'b1);
        check("init_write_reg_no", ifc.write_reg_no, k - 1);
        check("init_write_data",   ifc.write_data,   32'h0);
        check("init_busy",         ifc.init_busy,    1'b1);
        check("init_req0_ready",   ifc.req0_ready,   1'b0);
      end else begin
        check("run_entry_busy",      ifc.init_busy,  1'b0);
        check("run_entry_reg_write", ifc.reg_write,  1'b0);
        check("run_entry_req0_rdy",  ifc.req0_ready, 1'b1);
      end
    end
    @(posedge clk); #1;
    set_req0(1'b0, 0, '0);
    @(negedge clk);
    check("first_req_reg_write", ifc.reg_write,    1'b1);
    check("first_req_reg_no",    ifc.write_reg_no, 2'd1);
    check("first_req_data",      ifc.write_data,   32'hF0F0F0F0);

    // Reset while a write is presented: drops asynchronously
    rst_n = 1'b0;
    #1;
    check("async_rst_reg_write", ifc.reg_write, 1'b0);
    check("async_rst_init_busy", ifc.init_busy, 1'b1);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (REG_N + 1) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < REG_N; i++) check("reinit_rf", rf[i], INIT_VALUE);
    check("reinit_busy", ifc.init_busy, 1'b0);

    // Both valid, each drops once accepted: req0 then req1 on consecutive edges
    @(posedge clk); #1;
    set_req0(1'b1, 1, 32'hF0F0F0F0);
    set_req1(1'b1, 2, 32'hF8F8F8F8);
    grants.delete();
    cnt = 0;
    while ((ifc.req0_valid || ifc.req1_valid) && cnt < 10) begin
      cycle(acc0, acc1);
      if (acc0) begin grants.push_back(0); ifc.req0_valid = 1'b0; end
      if (acc1) begin grants.push_back(1); ifc.req1_valid = 1'b0; end
      cnt++;
    end
    check("pair_cycles",  cnt,           2);
    check("pair_grants",  grants.size(), 2);
    if (grants.size() == 2) begin
      check("pair_first",  grants[0], 0);
      check("pair_second", grants[1], 1);
    end

    // Continuous dual load for 6 cycles
    set_req0(1'b1, 1, 32'hF0F0F0F0);
    set_req1(1'b1, 2, 32'hF8F8F8F8);
    for (int k = 0; k < 6; k++) begin
      cycle(acc0, acc1);
      check("dual_grant", acc0 ? 0 : (acc1 ? 1 : 9), RR ? (k % 2) : 0);
    end
    ifc.req0_valid = 1'b0;
    cnt = 0;
    while (ifc.req1_valid && cnt < 10) begin
      cycle(acc0, acc1);
      if (acc1) ifc.req1_valid = 1'b0;
      cnt++;
    end
    check("dual_drain_timeout", ifc.req1_valid, 1'b0);

    // Same register from both: later grant persists
    @(posedge clk); #1;
    set_req0(1'b1, 3, 32'hFAFAFAFA);
    set_req1(1'b1, 3, 32'hFFFFFFFF);
    cnt = 0;
    while ((ifc.req0_valid || ifc.req1_valid) && cnt < 10) begin
      cycle(acc0, acc1);
      if (acc0) ifc.req0_valid = 1'b0;
      if (acc1) ifc.req1_valid = 1'b0;
      cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    check("same_reg_readback", rf[3], 32'hFFFFFFFF);

    // Randomized traffic obeying the hold-until-accepted rule
    @(posedge clk); #1;
    for (int k = 0; k < 400; k++) begin
      if (!ifc.req0_valid || acc0)
        set_req0($urandom_range(2, 0) != 0, $urandom_range(REG_N - 1, 0), $urandom);
      if (!ifc.req1_valid || acc1)
        set_req1($urandom_range(2, 0) != 0, $urandom_range(REG_N - 1, 0), $urandom);
      cycle(acc0, acc1);
    end
    set_req0(1'b0, 0, '0);
    set_req1(1'b0, 0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
